// File: rtl/mips_cpu_halt_monitor_if.sv
// Status bundle between mips_cpu_harvard, its bench and the halt monitor.
// slave: monitor view (CPU status in, verdict out); master: driver view.
interface mips_cpu_halt_monitor_if #(
  parameter int CNT_W = 16
);
  logic             clk_enable;
  logic             active;
  logic [31:0]      instr_address;
  logic [31:0]      register_v0;
  logic             check_en;
  logic [31:0]      expected_v0;
  logic             running;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic             vector_err;
  logic [CNT_W-1:0] cycle_count;
  logic [31:0]      final_v0;

  modport slave (
    input  clk_enable, active, instr_address,
    input  register_v0, check_en, expected_v0,
    output running, done, pass, fail, timeout,
    output vector_err, cycle_count, final_v0
  );

  modport master (
    output clk_enable, active, instr_address,
    output register_v0, check_en, expected_v0,
    input  running, done, pass, fail, timeout,
    input  vector_err, cycle_count, final_v0
  );
endinterface

// File: rtl/mips_cpu_halt_monitor.sv
// Watches CPU status, detects end of run, captures $v0, flags verdict.
// Ports: clk, reset (async high), bus (slave modport of the _if bundle).
module mips_cpu_halt_monitor #(
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR      = 32'h00000000,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          CNT_W          = 16
) (
  input logic clk,
  input logic reset,
  mips_cpu_halt_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    WAIT_START,
    RUN,
    HALT,
    TOUT
  } state_t;

  state_t           state_q, state_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             tout_q, tout_d;
  logic             vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      v0_q, v0_d;
  logic             halt_now;
  logic             good;

  assign halt_now = !bus.active
                 || (bus.instr_address == HALT_ADDR);
  // vector_err is already registered by the time RUN is evaluated
  assign good = !vec_q
             && (!bus.check_en
                 || bus.register_v0 == bus.expected_v0);

  always_comb begin
    state_d   = state_q;
    running_d = running_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    tout_d    = tout_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    v0_d      = v0_q;
    if (bus.clk_enable) begin
      unique case (state_q)
        WAIT_START: begin
          cnt_d = '0;
          if (bus.active) begin
            state_d   = RUN;
            running_d = 1'b1;
            if (bus.instr_address != RESET_VECTOR)
              vec_d = 1'b1;
          end
        end
        RUN: begin
          if (halt_now) begin
            state_d   = HALT;
            running_d = 1'b0;
            done_d    = 1'b1;
            v0_d      = bus.register_v0;
            pass_d    = good;
            fail_d    = !good;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = TOUT;
            running_d = 1'b0;
            done_d    = 1'b1;
            tout_d    = 1'b1;
            pass_d    = 1'b0;
            fail_d    = 1'b1;
            v0_d      = bus.register_v0;
            cnt_d     = CNT_MAX;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HALT, TOUT: begin
        end
        default: begin
          state_d = WAIT_START;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_START;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      tout_q    <= 1'b0;
      vec_q     <= 1'b0;
      cnt_q     <= '0;
      v0_q      <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      tout_q    <= tout_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      v0_q      <= v0_d;
    end
  end

  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.fail        = fail_q;
  assign bus.timeout     = tout_q;
  assign bus.vector_err  = vec_q;
  assign bus.cycle_count = cnt_q;
  assign bus.final_v0    = v0_q;

endmodule

// File: tb/tb_mips_cpu_halt_monitor.sv
// Scoreboard bench for mips_cpu_halt_monitor (TIMEOUT_CYCLES=8).
// Runs are edge lists; a list-level model predicts the verdict.
module tb_mips_cpu_halt_monitor;

  localparam logic [31:0] RV   = 32'hBFC00000;
  localparam logic [31:0] HA   = 32'h00000000;
  localparam int          T    = 8;
  localparam int          CW   = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_cpu_halt_monitor_if #(.CNT_W(CW)) bus();

  mips_cpu_halt_monitor #(
    .RESET_VECTOR(RV),
    .HALT_ADDR(HA),
    .TIMEOUT_CYCLES(T),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct {
    bit          en;
    bit          act;
    logic [31:0] addr;
    logic [31:0] v0;
    bit          chk;
    logic [31:0] ev;
    int          ecnt;
  } edge_t;

  typedef struct {
    bit          pass;
    bit          fail;
    bit          tout;
    bit          vec;
    int          cnt;
    logic [31:0] v0;
  } res_t;

  edge_t prog[$];
  res_t  sb[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic void add(bit en, bit act, logic [31:0] addr,
                              logic [31:0] v0, bit c,
                              logic [31:0] ev, int ecnt);
    edge_t e;
    e.en = en; e.act = act; e.addr = addr; e.v0 = v0;
    e.chk = c; e.ev = ev; e.ecnt = ecnt;
    prog.push_back(e);
  endfunction

  // Run = enabled edges after the first active one. The halt index h
  // is the number of plain run edges before the first halt condition.
  function automatic res_t model();
    edge_t e[$];
    res_t  r;
    int    first = -1;
    int    h = -1;
    int    idx;
    foreach (prog[i]) if (prog[i].en) e.push_back(prog[i]);
    foreach (e[i]) if (first < 0 && e[i].act) first = i;
    r.pass = 0; r.fail = 0; r.tout = 0; r.vec = 0; r.cnt = 0; r.v0 = '0;
    r.vec = (e[first].addr != RV);
    for (int i = first + 1; i < e.size(); i++)
      if (h < 0 && (!e[i].act || e[i].addr == HA)) h = i - first - 1;
    if (h >= 0 && h < T) begin
      idx = first + 1 + h;
      r.cnt = h;
      r.v0 = e[idx].v0;
      r.pass = !r.vec && (!e[idx].chk || e[idx].v0 == e[idx].ev);
      r.fail = !r.pass;
    end else begin
      idx = first + T;
      r.cnt = T;
      r.tout = 1;
      r.fail = 1;
      r.v0 = e[idx].v0;
    end
    return r;
  endfunction

  // Monitor: one scoreboard entry per rising done.
  bit done_seen = 0;
  always @(negedge clk) begin
    res_t r;
    if (!bus.done) done_seen = 0;
    else if (!done_seen) begin
      done_seen = 1;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        r = sb.pop_front();
        chk("pass", bus.pass, r.pass);
        chk("fail", bus.fail, r.fail);
        chk("timeout", bus.timeout, r.tout);
        chk("vector_err", bus.vector_err, r.vec);
        chk("cycle_count", bus.cycle_count, r.cnt);
        chk("final_v0", bus.final_v0, r.v0);
        chk("running_end", bus.running, 0);
      end
    end
  end

  task automatic idle_inputs();
    bus.clk_enable = 1'b1;
    bus.active = 1'b0;
    bus.instr_address = $urandom;
    bus.register_v0 = $urandom;
    bus.check_en = 1'b0;
    bus.expected_v0 = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_run();
    int pend = -1;
    sb.push_back(model());
    foreach (prog[i]) begin
      @(negedge clk);
      if (pend >= 0) chk("cnt_frozen", bus.cycle_count, pend);
      bus.clk_enable = prog[i].en;
      bus.active = prog[i].act;
      bus.instr_address = prog[i].addr;
      bus.register_v0 = prog[i].v0;
      bus.check_en = prog[i].chk;
      bus.expected_v0 = prog[i].ev;
      pend = prog[i].ecnt;
    end
    @(negedge clk);
    if (pend >= 0) chk("cnt_frozen", bus.cycle_count, pend);
    idle_inputs();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL done_wait: got 0 expected 1");
      sb.delete();
    end
    prog.delete();
  endtask

  // Straight-line run: n plain fetches after the reset vector, then halt.
  task automatic simple_run(logic [31:0] a0, int n, bit by_drop,
                            logic [31:0] v0, bit c, logic [31:0] ev);
    add(1, 1, a0, $urandom, $urandom_range(0, 1), $urandom, -1);
    for (int k = 1; k <= n; k++)
      add(1, 1, a0 + 32'(4 * k), $urandom, $urandom_range(0, 1),
          $urandom, -1);
    if (by_drop) add(1, 0, a0 + 32'h100, v0, c, ev, -1);
    else         add(1, 1, HA, v0, c, ev, -1);
    drive_run();
  endtask

  task automatic random_run();
    int          w;
    int          l;
    bit          c;
    logic [31:0] ev;
    logic [31:0] a0;
    c = 1'($urandom_range(0, 1));
    ev = $urandom;
    w = $urandom_range(0, 3);
    for (int k = 0; k < w; k++)
      add(1, 0, $urandom, $urandom, 0, $urandom, -1);
    a0 = ($urandom_range(0, 9) == 0) ? RV + 32'h4 : RV;
    add(1, 1, a0, $urandom, 0, $urandom, -1);
    l = $urandom_range(0, 11);
    for (int k = 1; k <= l; k++) begin
      if ($urandom_range(0, 6) == 0)
        add(0, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? HA : $urandom,
            $urandom, 1'($urandom_range(0, 1)), $urandom, -1);
      add(1, 1, RV + 32'(4 * k), $urandom,
          1'($urandom_range(0, 1)), $urandom, -1);
    end
    add(1, ($urandom_range(0, 1) != 0),
        ($urandom_range(0, 1) != 0) ? HA : RV + 32'h200,
        ($urandom_range(0, 1) != 0) ? ev : $urandom, c, ev, -1);
    // a drop with nonzero address must still be a halt
    if (!prog[prog.size()-1].act) prog[prog.size()-1].addr = RV + 32'h200;
    else prog[prog.size()-1].addr = HA;
    drive_run();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_outputs",
        {bus.running, bus.done, bus.pass, bus.fail, bus.timeout,
         bus.vector_err, bus.cycle_count, bus.final_v0}, 0);
    @(negedge clk);
    reset = 1'b0;

    // nominal pass, then wrong result
    simple_run(RV, 4, 0, 32'd14, 1, 32'd14);
    do_reset();
    simple_run(RV, 4, 0, 32'd15, 1, 32'd14);
    // bad reset vector
    do_reset();
    simple_run(RV + 32'h4, 2, 0, 32'd9, 0, 32'd1);

    // timeout: loops between two addresses
    do_reset();
    add(1, 1, RV, 32'd1, 0, 0, -1);
    for (int k = 0; k < 12; k++)
      add(1, 1, (k % 2 == 0) ? RV + 32'h4 : RV, 32'(k), 0, 0, -1);
    drive_run();

    // halt arrives on the timeout edge; then drop-to-halt
    do_reset();
    simple_run(RV, 7, 0, 32'h5A5A, 1, 32'h5A5A);
    do_reset();
    simple_run(RV, 3, 1, 32'h77, 1, 32'h77);

    // clk_enable low for 5 edges with halting junk on the inputs
    do_reset();
    add(1, 1, RV, 0, 0, 0, -1);
    for (int k = 1; k <= 3; k++) add(1, 1, RV + 32'(4 * k), 0, 0, 0, -1);
    for (int k = 0; k < 5; k++) add(0, k % 2, HA, 32'd3, 1, 0, 3);
    add(1, 1, RV + 32'h10, 0, 0, 0, -1);
    add(1, 1, RV + 32'h14, 0, 0, 0, -1);
    add(1, 1, HA, 32'hCAFE, 1, 32'hCAFE, -1);
    drive_run();

    // async reset mid-run, bad vector so flags are non-zero
    do_reset();
    @(negedge clk);
    bus.active = 1'b1;
    bus.instr_address = RV + 32'h8;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.instr_address = RV + 32'(8 + 4 * k);
    end
    @(posedge clk);
    #2;
    chk("mid_running", {bus.running, bus.vector_err}, 2'b11);
    reset = 1'b1;
    #1;
    chk("mid_reset_outputs",
        {bus.running, bus.done, bus.pass, bus.fail, bus.timeout,
         bus.vector_err, bus.cycle_count, bus.final_v0}, 0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    simple_run(RV, 5, 0, 32'd42, 1, 32'd42);

    for (int n = 0; n < 40; n++) begin
      do_reset();
      random_run();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/mips_cpu_halt_monitor.md
Name: mips_cpu_halt_monitor

Overview:
- Sits directly downstream of mips_cpu_harvard and consumes its status outputs: active, instr_address and register_v0.
- Decides when a program run has finished, by halt-address fetch or by active dropping, and captures the final register_v0.
- Compares the captured value against an expected value and flags pass, fail, timeout or a bad reset vector.
- Used by every directed CPU bench in place of per-test ad-hoc assertions.

Parameters:
- RESET_VECTOR, 32'hBFC00000, address the first fetch after reset must present.
- HALT_ADDR, 32'h00000000, fetch address that marks program termination.
- TIMEOUT_CYCLES, 1000, maximum enabled RUN cycles before declaring timeout (must be >= 2).
- CNT_W, 16, width of the cycle counter (must satisfy 2^CNT_W > TIMEOUT_CYCLES).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- clk_enable  input  1  when 0, all state and outputs hold.
- active  input  1  CPU active flag.
- instr_address  input  32  CPU fetch address.
- register_v0  input  32  CPU $v0 value.
- check_en  input  1  1 = compare final $v0 against expected_v0.
- expected_v0  input  32  expected final $v0, sampled at halt.
- running  output  1  high while in RUN.
- done  output  1  sticky; run finished (halt or timeout).
- pass  output  1  sticky; valid when done.
- fail  output  1  sticky; valid when done.
- timeout  output  1  sticky; run hit TIMEOUT_CYCLES.
- vector_err  output  1  sticky; first fetch was not RESET_VECTOR.
- cycle_count  output  CNT_W  enabled RUN edges counted before the terminating edge.
- final_v0  output  32  register_v0 captured at the terminating edge.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high. Reset forces state WAIT_START and drives every output to 0.
- Reset mid-run: the monitor abandons the run immediately, with no residual flags.
- clk_enable: all transitions happen only on a rising clk edge with clk_enable=1. With clk_enable=0 nothing changes, including the counter.
- State WAIT_START:
  - cycle_count is held at 0.
  - On an edge with active=1: go to RUN and set running=1.
  - On that same edge, if instr_address != RESET_VECTOR, set vector_err=1. vector_err stays set until reset.
- State RUN, evaluated per enabled edge in priority order:
  1. Halt: active=0 or instr_address == HALT_ADDR.
     - Capture final_v0 <= register_v0. Set done=1, running=0, go to HALT.
     - pass <= !vector_err && (!check_en || register_v0 == expected_v0). fail <= !pass.
     - cycle_count is not incremented on this edge.
  2. Timeout: cycle_count == TIMEOUT_CYCLES-1.
     - Go to TIMEOUT. Set done=1, timeout=1, fail=1, pass=0, running=0.
     - Capture final_v0 <= register_v0. cycle_count <= TIMEOUT_CYCLES.
  3. Otherwise cycle_count <= cycle_count + 1.
- Halt has priority over timeout on the same edge.
- States HALT and TIMEOUT: terminal. All outputs hold until reset, and the inputs are ignored.
- Output encoding:
  - pass and fail are never both 1.
  - Both are 0 while done=0.
  - All outputs are registered, with no combinational path from inputs to outputs.
- Comparison: full 32-bit equality. expected_v0 is sampled only on the halting edge, so changes to it before or after that edge have no effect.
- Width rule: cycle_count never wraps, because it stops at TIMEOUT_CYCLES.

Test Plan:
- Nominal run: reset pulse; check_en=1, expected_v0=14. active=1 with fetches BFC00000, BFC00004, BFC00008, BFC0000C, BFC00010, then 0, while register_v0=14 at the address-0 edge. Required: done=1, pass=1, fail=0, cycle_count=4, final_v0=14, vector_err=0.
- Wrong result: same sequence with register_v0=15. Required: done=1, fail=1, pass=0, final_v0=15.
- Bad reset vector: first active fetch at BFC00004, check_en=0, halt normally. Required: vector_err=1, fail=1, pass=0.
- Timeout: TIMEOUT_CYCLES=8; CPU loops on BFC00000/BFC00004 and never halts. Required: on the 8th RUN edge done=1, timeout=1, fail=1, cycle_count=8.
- Simultaneous halt and timeout: TIMEOUT_CYCLES=8, address 0 arrives on the 8th RUN edge. Required: timeout=0, pass by comparison, cycle_count=7. A separate case with active dropping to 0 while instr_address != 0 must also halt.
- clk_enable and reset mid-run:
  - With clk_enable=0 for 5 cycles during RUN, cycle_count is frozen.
  - Asserting reset asynchronously between edges clears all outputs immediately.
  - A subsequent clean run passes.
